// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for the iterative shift-add multiplier: issues load/add/shift
// strobes for one multiply per start pulse and owns the result display scroll window.
module mult_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int ITER_W  = 4,
    parameter int WIN_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              left,
    input  logic              right,
    input  logic              mp_lsb,
    output logic              load,
    output logic              add_en,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter,
    output logic [1:0]        win_sel
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_t;

    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(WIDTH - 1);
    localparam logic [1:0]        WIN_TOP   = 2'(WIN_MAX);

    state_t state;
    state_t state_next;

    // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        add_en     = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                load       = 1'b1;
                busy       = 1'b1;
                state_next = CALC;
            end
            CALC: begin
                shift_en = 1'b1;
                add_en   = mp_lsb;
                busy     = 1'b1;
                if (iter == ITER_LAST) state_next = DONE;
            end
            DONE: if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // The counter holds at its last value in DONE so the final iteration stays visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter <= '0;
        end else if (state == LOAD) begin
            iter <= '0;
        end else if (state == CALC && iter != ITER_LAST) begin
            iter <= iter + ITER_W'(1);
        end
    end

    // Registered from the next state so done drops on the same edge that accepts a restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done <= 1'b0;
        else     done <= (state_next == DONE);
    end

    // Scrolling only in DONE; a simultaneous start takes priority and LOAD clears the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_sel <= 2'd0;
        end else if (state == LOAD) begin
            win_sel <= 2'd0;
        end else if (state == DONE && !start) begin
            if (left && !right && win_sel < WIN_TOP)
                win_sel <= win_sel + 2'd1;
            else if (right && !left && win_sel != 2'd0)
                win_sel <= win_sel - 2'd1;
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: a cycle-timeline reference model plus a small
// shift-add datapath emulator that verifies the strobes really produce a*b.
module tb_mult_seq_ctrl;

    localparam int WIDTH   = 8;
    localparam int ITER_W  = 4;
    localparam int WIN_MAX = 2;

    logic              clk;
    logic              rst;
    logic              start;
    logic              left;
    logic              right;
    logic              mp_lsb;
    logic              load;
    logic              add_en;
    logic              shift_en;
    logic              busy;
    logic              done;
    logic [ITER_W-1:0] iter;
    logic [1:0]        win_sel;

    mult_seq_ctrl #(.WIDTH(WIDTH), .ITER_W(ITER_W), .WIN_MAX(WIN_MAX)) dut (
        .clk(clk), .rst(rst), .start(start), .left(left), .right(right),
        .mp_lsb(mp_lsb), .load(load), .add_en(add_en), .shift_en(shift_en),
        .busy(busy), .done(done), .iter(iter), .win_sel(win_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference timeline: k = cycles since the accepted start (0 = no run, 1 = load cycle).
    int k         = 0;
    int exp_win   = 0;
    int last_iter = 0;
    logic [7:0]  next_a, next_b, run_a, run_b;
    logic [7:0]  mp_reg;
    logic [15:0] mc_reg, acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_iter();
        if (k == 0) return 0;
        if (k == 1) return last_iter;
        if (k <= WIDTH + 1) return k - 2;
        return WIDTH - 1;
    endfunction

    // One clock cycle: drive inputs, check this cycle, advance model and emulator at the edge.
    task automatic tick(input logic s, input logic l, input logic r);
        logic ld, ad, sh, busy_m, done_m, shift_m;
        start = s; left = l; right = r;
        #1;
        shift_m = (k >= 2 && k <= WIDTH + 1);
        busy_m  = (k >= 1 && k <= WIDTH + 1);
        done_m  = (k >= WIDTH + 2);
        check("load", load, k == 1);
        check("shift_en", shift_en, shift_m);
        check("add_en", add_en, shift_m && mp_lsb);
        check("busy", busy, busy_m);
        check("done", done, done_m);
        check("win_sel", win_sel, exp_win);
        check("iter", iter, exp_iter());
        if (k == WIDTH + 2) check("product", acc, run_a * run_b);
        ld = load; ad = add_en; sh = shift_en;
        @(posedge clk);
        last_iter = exp_iter();
        if (k == 1) exp_win = 0;
        else if (done_m && !s) begin
            if (l && !r && exp_win < WIN_MAX) exp_win++;
            else if (r && !l && exp_win > 0) exp_win--;
        end
        if (s && !busy_m) begin
            k = 1; run_a = next_a; run_b = next_b;
        end else if (k > 0 && k < WIDTH + 2) begin
            k++;
        end
        if (ld) begin
            mp_reg = next_a; mc_reg = {8'd0, next_b}; acc = '0;
        end else begin
            if (ad) acc = acc + mc_reg;
            if (sh) begin mp_reg = mp_reg >> 1; mc_reg = mc_reg << 1; end
        end
        mp_lsb = mp_reg[0];
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before the next edge.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        check("rst_load", load, 0);
        check("rst_shift", shift_en, 0);
        check("rst_add", add_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_win", win_sel, 0);
        check("rst_iter", iter, 0);
        k = 0; exp_win = 0; last_iter = 0;
        mp_reg = '0; mc_reg = '0; acc = '0; mp_lsb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        start = 0; left = 0; right = 0; mp_lsb = 0; rst = 0;
        next_a = 8'h05; next_b = 8'($urandom);
        run_a = 0; run_b = 0; mp_reg = 0; mc_reg = 0; acc = 0;
        @(negedge clk);
        async_reset();
        repeat (20) tick(0, 0, 0);

        // Basic multiply with MP = 5, then scroll saturation in DONE.
        tick(1, 0, 0);
        for (int c = 1; c <= 11; c++) tick(0, 0, 0);
        repeat (3) tick(0, 1, 0);
        repeat (3) tick(0, 0, 1);
        tick(0, 1, 1);
        tick(0, 0, 0);

        // Extra starts during the run, scroll attempts during CALC.
        next_b = 8'($urandom);
        tick(1, 0, 0);
        for (int c = 1; c <= 11; c++) tick(c == 3 || c == 7, c == 4, c == 5);

        // Restart from DONE with the window at the top; a start beside left must win.
        repeat (3) tick(0, 1, 0);
        next_a = 8'hff; next_b = 8'hff;
        tick(1, 1, 0);
        for (int c = 1; c <= 11; c++) tick(0, 0, 0);

        // Async reset mid-CALC, then a normal multiply.
        next_a = 8'($urandom); next_b = 8'($urandom);
        tick(1, 0, 0);
        for (int c = 1; c <= 5; c++) tick(0, 0, 0);
        async_reset();
        tick(0, 0, 0);
        tick(1, 0, 0);
        for (int c = 1; c <= 11; c++) tick(0, 0, 0);

        // Randomized runs with stray starts and scroll pulses in every phase.
        repeat (25) begin
            while (k >= 1 && k <= WIDTH + 1) tick(0, 0, 0);
            next_a = 8'($urandom); next_b = 8'($urandom);
            tick(1, 1'($urandom), 1'($urandom));
            repeat (10 + $urandom_range(0, 8))
                tick($urandom_range(0, 9) == 0, 1'($urandom), 1'($urandom));
        end
        while (k >= 1 && k <= WIDTH + 1) tick(0, 0, 0);
        tick(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
